and_reduce_pipelined: RTL and testbench
=======================================

# and_reduce_pipelined

Pipelined, handshaked reduction of a wide input vector to one result bit, using AND, OR or XOR per transaction. It serves paths where a single-level reduction gate is too long for the clock period. The reduction tree is split into registered stages, one GROUP-ary level per stage. Valid/ready flow control lets the block sit between any two streaming interfaces in the datapath.

## Interface
- WIDTH, 16: input vector width, ≥2.
- GROUP, 4: fan-in per tree level, ≥2.
- TAG_W, 4: width of the sideband tag carried with each transaction.
- Derived S = ceil(log_GROUP(WIDTH)) stages (16/4 → 2; 32/4 → 3).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  vector to reduce.
- in_op  in  2  00 AND, 01 OR, 10 XOR, 11 reserved (treated as AND).
- in_tag  in  TAG_W  sideband; returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  1  reduction result.
- out_tag  out  TAG_W  tag of the result's transaction.
- busy  out  1  OR of all stage valid bits.

## Operation
- Transfer occurs on a cycle with valid && ready on either side.
- Stage k (0..S-1) holds its own state:
  - valid bit v[k];
  - partial vector ceil(WIDTH/GROUP^(k+1)) bits wide;
  - op and tag.
- Each stage reduces consecutive GROUP-bit groups of the previous vector using the transaction's op.
- Last partial group is padded with the identity element: 1 for AND, 0 for OR/XOR. Example: WIDTH=10, GROUP=4 reduces bits [3:0], [7:4], [9:8]+pad.
- Stage S-1 output is out_data; out_valid = v[S-1].
- Stall rule: stage k advances when !v[k] || ready into stage k+1. Stage S-1's "next ready" is out_ready.
  - in_ready = !v[0] || advance[0].
  - The ready chain is combinational through the stages (no skid buffers), giving full throughput.
- A stalled stage holds data, op and tag stable. out_valid never drops without an out_ready handshake.
- Bubbles collapse: an empty stage accepts new data even while downstream stages are stalled.
- Transactions are never reordered, duplicated or dropped.
- in_op=11 behaves exactly as 00; out_tag is still preserved.

## Timing
- Reset values (asynchronous, effective during reset):
  - all v[k]=0, out_valid=0, out_data=0, out_tag=0, busy=0;
  - in_ready=1 while reset is deasserted and stage 0 is empty.
- While reset is high, in_ready=0.
- Latency: a transaction accepted in cycle t appears with out_valid=1 in cycle t+S, given no stall.
- Throughput: 1 transaction/cycle while out_ready=1.
- Capacity: S transactions. With out_ready held low from empty, exactly S are accepted, then in_ready=0.
- Full pipe: releasing out_ready for one cycle lets in_ready=1 in that same cycle (simultaneous drain and fill).
- Reset mid-operation: all in-flight transactions are discarded, and out_valid falls asynchronously. There is no partial result after reset release.
- No combinational path exists from in_valid/in_data to out_*.
- The only combinational path from out_ready goes to in_ready.

## Structure
- Shared package and_reduce_pkg holds:
  - op_t enum: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_RSVD=2'b11;
  - function identity(op_t) returning the pad bit;
  - function num_stages(WIDTH, GROUP).
- Sub-module and_reduce_stage performs one tree level plus its register:
  - parameters IN_W, GROUP, TAG_W;
  - local valid/ready handshake.
- Top level instantiates S stages with generate and chains the handshakes.

## Test plan
- Basic pass, WIDTH=16, GROUP=4, out_ready=1:
  - in_data=16'hFFFF, op AND, tag 3 → out_data=1, tag 3 at t+2.
  - 16'hFFFE AND → 0.
  - 16'h0000 OR → 0.
  - 16'h0001 XOR → 1.
- Back-to-back stream of 8 random vectors with mixed ops → 8 results in order, each matching the golden reduction, one per cycle, latency 2.
- Backpressure, out_ready=0 from empty, in_valid=1 continuously:
  - exactly 2 accepted, then in_ready=0 and busy=1;
  - raise out_ready → results drain in order, in_ready=1 the same cycle.
- Padding, WIDTH=10, GROUP=4:
  - 10'h3FF AND → 1.
  - 10'h200 XOR → 1.
  - 10'h000 OR → 0.
- Reserved op: in_op=11, in_data=16'hFFFF, tag 9 → out_data=1, tag 9.
- Reset mid-stream:
  - assert reset with 2 transactions in flight → out_valid=0 and busy=0 immediately;
  - after release, the first new input's result appears at t+2 with no stale output.

Source files
------------

// File: rtl/and_reduce_pkg.sv
// rtl/and_reduce_pkg.sv - shared ops, pad identity and tree sizing helpers for and_reduce_pipelined
package and_reduce_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    // Pad bit that leaves a group's reduction unchanged; the reserved op acts as AND.
    function automatic logic identity(op_t op);
        return (op == OP_AND) || (op == OP_RSVD);
    endfunction

    function automatic int ceil_div(int a, int b);
        return (a + b - 1) / b;
    endfunction

    // Tree levels needed to fold WIDTH bits down to one, GROUP bits per level.
    function automatic int num_stages(int width, int group);
        int w;
        int s;
        w = width;
        s = 0;
        while (w > 1) begin
            w = ceil_div(w, group);
            s++;
        end
        return s;
    endfunction

    // Width of the partial vector held by stage k; k = -1 gives the input width.
    function automatic int stage_width(int width, int group, int k);
        int w;
        w = width;
        for (int i = 0; i <= k; i++) begin
            w = ceil_div(w, group);
        end
        return w;
    endfunction

endpackage

// File: rtl/and_reduce_pipelined_if.sv
// rtl/and_reduce_pipelined_if.sv - input/output stream bundle of and_reduce_pipelined
// master: producer/consumer side (drives in_*, out_ready); slave: the reduction block.
interface and_reduce_pipelined_if
    import and_reduce_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    op_t              in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_data, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  in_valid, in_data, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/and_reduce_stage.sv
// rtl/and_reduce_stage.sv - one registered GROUP-ary level of the reduction tree
// Ports: clk, reset (async high); in_* upstream valid/ready with IN_W-bit vector, op, tag;
// out_* downstream valid/ready with ceil(IN_W/GROUP)-bit partial vector, op, tag.
module and_reduce_stage
    import and_reduce_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int GROUP = 4,
    parameter int TAG_W = 4,
    localparam int OUT_W = (IN_W + GROUP - 1) / GROUP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  op_t              in_op_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output op_t              out_op_o,
    output logic [TAG_W-1:0] out_tag_o
);
    localparam int PAD_W = OUT_W * GROUP;

    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q,  data_d;
    op_t              op_q,    op_d;
    logic [TAG_W-1:0] tag_q,   tag_d;
    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] reduced;

    // Empty or draining this cycle; held low during reset so nothing is accepted.
    assign in_ready_o = !reset && (!valid_q || out_ready_i);

    always_comb begin
        padded = {PAD_W{identity(in_op_i)}};
        padded[IN_W-1:0] = in_data_i;
        reduced = '0;
        for (int j = 0; j < OUT_W; j++) begin
            case (in_op_i)
                OP_OR:   reduced[j] = |padded[j*GROUP +: GROUP];
                OP_XOR:  reduced[j] = ^padded[j*GROUP +: GROUP];
                default: reduced[j] = &padded[j*GROUP +: GROUP];
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        tag_d   = tag_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = reduced;
                op_d   = in_op_i;
                tag_d  = in_tag_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= OP_AND;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_op_o    = op_q;
    assign out_tag_o   = tag_q;
endmodule

// File: rtl/and_reduce_pipelined.sv
// rtl/and_reduce_pipelined.sv - pipelined valid/ready AND/OR/XOR reduction of a wide vector
// Ports: clk, reset (async high); bus (slave): in_valid/in_ready/in_data/in_op/in_tag,
// out_valid/out_ready/out_data/out_tag, busy (any stage holding a transaction).
module and_reduce_pipelined
    import and_reduce_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    and_reduce_pipelined_if.slave  bus
);
    localparam int S = num_stages(WIDTH, GROUP);

    // Index k is the input side of stage k; index S is the block output.
    logic             v_chain   [0:S];
    logic             rdy_chain [0:S];
    op_t              op_chain  [0:S];
    logic [TAG_W-1:0] tag_chain [0:S];

    assign v_chain[0]   = bus.in_valid;
    assign op_chain[0]  = bus.in_op;
    assign tag_chain[0] = bus.in_tag;
    assign rdy_chain[S] = bus.out_ready;

    for (genvar k = 0; k < S; k++) begin : g_st
        localparam int IW = stage_width(WIDTH, GROUP, k - 1);
        localparam int OW = stage_width(WIDTH, GROUP, k);

        logic [IW-1:0] din;
        logic [OW-1:0] dout;

        if (k == 0) begin : g_first
            assign din = bus.in_data;
        end else begin : g_next
            assign din = g_st[k-1].dout;
        end

        and_reduce_stage #(
            .IN_W  (IW),
            .GROUP (GROUP),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .in_valid_i  (v_chain[k]),
            .in_ready_o  (rdy_chain[k]),
            .in_data_i   (din),
            .in_op_i     (op_chain[k]),
            .in_tag_i    (tag_chain[k]),
            .out_valid_o (v_chain[k+1]),
            .out_ready_i (rdy_chain[k+1]),
            .out_data_o  (dout),
            .out_op_o    (op_chain[k+1]),
            .out_tag_o   (tag_chain[k+1])
        );
    end

    logic busy_c;
    always_comb begin
        busy_c = 1'b0;
        for (int k = 1; k <= S; k++) begin
            busy_c = busy_c | v_chain[k];
        end
    end

    assign bus.in_ready  = rdy_chain[0];
    assign bus.out_valid = v_chain[S];
    assign bus.out_data  = g_st[S-1].dout[0];
    assign bus.out_tag   = tag_chain[S];
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_and_reduce_pipelined.sv
// tb/tb_and_reduce_pipelined.sv - directed self-checking bench for and_reduce_pipelined
module tb_and_reduce_pipelined;
    import and_reduce_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    and_reduce_pipelined_if #(.WIDTH(16), .TAG_W(4)) bus16 ();
    and_reduce_pipelined_if #(.WIDTH(10), .TAG_W(4)) bus10 ();

    and_reduce_pipelined #(.WIDTH(16), .GROUP(4), .TAG_W(4)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    and_reduce_pipelined #(.WIDTH(10), .GROUP(4), .TAG_W(4)) dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One transaction into both DUTs with out_ready high; checks latency 2 and the result.
    task automatic apply(input string name, input logic [15:0] d, input logic [1:0] op,
                         input logic [3:0] tag, input logic e16, input logic e10);
        @(negedge clk);
        chk({name, ".rdy16"}, bus16.in_ready, 1);
        chk({name, ".rdy10"}, bus10.in_ready, 1);
        bus16.in_valid = 1'b1; bus16.in_data = d;      bus16.in_op = op_t'(op); bus16.in_tag = tag;
        bus10.in_valid = 1'b1; bus10.in_data = d[9:0]; bus10.in_op = op_t'(op); bus10.in_tag = tag;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus10.in_valid = 1'b0;
        chk({name, ".lat16"}, bus16.out_valid, 0);
        chk({name, ".lat10"}, bus10.out_valid, 0);
        @(negedge clk);
        chk({name, ".ov16"},  bus16.out_valid, 1);
        chk({name, ".d16"},   bus16.out_data,  e16);
        chk({name, ".tag16"}, bus16.out_tag,   tag);
        chk({name, ".ov10"},  bus10.out_valid, 1);
        chk({name, ".d10"},   bus10.out_data,  e10);
        chk({name, ".tag10"}, bus10.out_tag,   tag);
    endtask

    logic [15:0] s_data [8];
    logic [1:0]  s_op   [8];
    logic        s_exp  [8];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_op = OP_AND; bus16.in_tag = '0; bus16.out_ready = 1'b1;
        bus10.in_valid = 1'b0; bus10.in_data = '0; bus10.in_op = OP_AND; bus10.in_tag = '0; bus10.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst.out_valid", bus16.out_valid, 0);
        chk("rst.out_data",  bus16.out_data,  0);
        chk("rst.out_tag",   bus16.out_tag,   0);
        chk("rst.busy",      bus16.busy,      0);
        chk("rst.in_ready",  bus16.in_ready,  0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel.in_ready", bus16.in_ready, 1);

        // Basic pass (WIDTH=10 DUT sees the low 10 bits)
        apply("and_ffff", 16'hFFFF, 2'b00, 4'd3, 1'b1, 1'b1);
        apply("and_fffe", 16'hFFFE, 2'b00, 4'd4, 1'b0, 1'b0);
        apply("or_0000",  16'h0000, 2'b01, 4'd5, 1'b0, 1'b0);
        apply("xor_0001", 16'h0001, 2'b10, 4'd6, 1'b1, 1'b1);

        // Padding cases for WIDTH=10, GROUP=4
        apply("pad_and", 16'h03FF, 2'b00, 4'd7, 1'b0, 1'b1);
        apply("pad_xor", 16'h0200, 2'b10, 4'd8, 1'b1, 1'b1);
        apply("pad_or",  16'h0000, 2'b01, 4'd1, 1'b0, 1'b0);

        // Reserved op behaves as AND
        apply("rsvd", 16'hFFFF, 2'b11, 4'd9, 1'b1, 1'b1);

        // Back-to-back stream, one result per cycle at latency 2
        s_data[0] = 16'hFFFF; s_op[0] = 2'b01; s_exp[0] = 1'b1;
        s_data[1] = 16'h8000; s_op[1] = 2'b00; s_exp[1] = 1'b0;
        s_data[2] = 16'h0003; s_op[2] = 2'b10; s_exp[2] = 1'b0;
        s_data[3] = 16'h0007; s_op[3] = 2'b10; s_exp[3] = 1'b1;
        s_data[4] = 16'h0000; s_op[4] = 2'b01; s_exp[4] = 1'b0;
        s_data[5] = 16'hFFFF; s_op[5] = 2'b10; s_exp[5] = 1'b0;
        s_data[6] = 16'h1249; s_op[6] = 2'b10; s_exp[6] = 1'b1;
        s_data[7] = 16'h0100; s_op[7] = 2'b01; s_exp[7] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk($sformatf("strm%0d.ov", j), bus16.out_valid, (j >= 2) ? 1 : 0);
            if (j >= 2) begin
                chk($sformatf("strm%0d.d", j - 2),   bus16.out_data, s_exp[j-2]);
                chk($sformatf("strm%0d.tag", j - 2), bus16.out_tag,  j - 2);
            end
            if (j < 8) begin
                chk($sformatf("strm%0d.rdy", j), bus16.in_ready, 1);
                bus16.in_valid = 1'b1; bus16.in_data = s_data[j];
                bus16.in_op = op_t'(s_op[j]); bus16.in_tag = 4'(j);
            end else begin
                bus16.in_valid = 1'b0;
            end
        end

        // Backpressure from empty: capacity 2, then simultaneous drain and fill
        @(negedge clk);
        chk("bp.empty", bus16.busy, 0);
        bus16.out_ready = 1'b0;
        bus16.in_valid = 1'b1; bus16.in_data = 16'hFFFF; bus16.in_op = OP_AND; bus16.in_tag = 4'd1;
        @(negedge clk);
        chk("bp.rdy1", bus16.in_ready, 1);
        chk("bp.ov1",  bus16.out_valid, 0);
        bus16.in_data = 16'h0000; bus16.in_op = OP_AND; bus16.in_tag = 4'd2;
        @(negedge clk);
        bus16.in_data = 16'h0001; bus16.in_op = OP_OR; bus16.in_tag = 4'd4;
        chk("bp.full_rdy", bus16.in_ready, 0);
        chk("bp.busy",     bus16.busy, 1);
        chk("bp.ov2",      bus16.out_valid, 1);
        @(negedge clk);
        chk("bp.hold_rdy", bus16.in_ready, 0);
        chk("bp.hold_d",   bus16.out_data, 1);
        chk("bp.hold_tag", bus16.out_tag, 1);
        bus16.out_ready = 1'b1;
        #1;
        chk("bp.same_cycle_rdy", bus16.in_ready, 1);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        chk("bp.r1.ov",  bus16.out_valid, 1);
        chk("bp.r1.d",   bus16.out_data, 0);
        chk("bp.r1.tag", bus16.out_tag, 2);
        @(negedge clk);
        chk("bp.r2.ov",  bus16.out_valid, 1);
        chk("bp.r2.d",   bus16.out_data, 1);
        chk("bp.r2.tag", bus16.out_tag, 4);
        @(negedge clk);
        chk("bp.drained", bus16.busy, 0);

        // Reset with two transactions in flight
        bus16.out_ready = 1'b0;
        bus16.in_valid = 1'b1; bus16.in_data = 16'hFFFF; bus16.in_op = OP_AND; bus16.in_tag = 4'd5;
        @(negedge clk);
        bus16.in_data = 16'h0000; bus16.in_op = OP_OR; bus16.in_tag = 4'd7;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        chk("mid.ov_before", bus16.out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid.ov",   bus16.out_valid, 0);
        chk("mid.busy", bus16.busy, 0);
        chk("mid.rdy",  bus16.in_ready, 0);
        chk("mid.tag",  bus16.out_tag, 0);
        @(negedge clk);
        reset = 1'b0;
        bus16.out_ready = 1'b1;
        #1;
        chk("post.ov",   bus16.out_valid, 0);
        chk("post.busy", bus16.busy, 0);
        chk("post.rdy",  bus16.in_ready, 1);
        apply("post_xor", 16'h0000, 2'b10, 4'd6, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
